// File: rtl/int_to_float_pkg.sv
// Shared widths, exponent constants and the packed single-precision layout
// used by the int_to_float converter.
package int_to_float_pkg;

    localparam int FLOAT_BIAS = 127;
    localparam int EXP_W      = 8;
    localparam int FRAC_W     = 23;
    localparam int INT_W      = 32;

    // Biased exponent of a value whose leading one sits at bit INT_W-1.
    localparam int EXP_TOP    = FLOAT_BIAS + INT_W - 1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exponent;
        logic [FRAC_W-1:0] fraction;
    } float_t;

endpackage

// File: rtl/int_to_float_lzc32.sv
// Combinational 32-bit leading-zero counter; an all-zero input yields 32.
module lzc32
    import int_to_float_pkg::*;
(
    input  logic [INT_W-1:0] i_value,
    output logic [5:0]       o_count
);

    // Scanning upward lets the highest set bit overwrite any lower hit.
    always_comb begin
        o_count = 6'd32;
        for (int i = 0; i < INT_W; i++) begin
            if (i_value[i]) begin
                o_count = 6'(INT_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/int_to_float.sv
// Three-stage int32 -> IEEE-754 single converter, round to nearest even.
// Optional macro INT_TO_FLOAT_INEXACT_EN adds the out_inexact flag output.
module int_to_float
    import int_to_float_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [INT_W-1:0] in_a,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      out_z,
    output logic             out_valid,
    input  logic             out_ready
`ifdef INT_TO_FLOAT_INEXACT_EN
    ,
    output logic             out_inexact
`endif
);

    logic             w_advance;
    logic [INT_W-1:0] w_mag;
    logic [5:0]       w_lz;
    logic [INT_W-1:0] w_norm;

    logic             r_s1_valid;
    logic             r_s1_sign;
    logic [INT_W-1:0] r_s1_mag;

    logic             r_s2_valid;
    logic             r_s2_sign;
    logic             r_s2_zero;
    logic [5:0]       r_s2_lz;
    logic [INT_W-1:0] r_s2_norm;

    logic             r_out_valid;
    logic [31:0]      r_out_z;

    // The whole pipeline moves as one unit whenever the output slot can drain.
    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_out_valid;
    assign out_z     = r_out_z;

    assign w_mag = in_a[INT_W-1] ? (~in_a + 32'd1) : in_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_mag   <= '0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            r_s1_sign  <= in_a[INT_W-1];
            r_s1_mag   <= w_mag;
        end
    end

    lzc32 u_lzc (
        .i_value (r_s1_mag),
        .o_count (w_lz)
    );

    assign w_norm = r_s1_mag << w_lz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_s2_lz    <= '0;
            r_s2_norm  <= '0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
            r_s2_zero  <= (r_s1_mag == '0);
            r_s2_lz    <= w_lz;
            r_s2_norm  <= w_norm;
        end
    end

    logic              w_guard;
    logic              w_sticky;
    logic              w_round_up;
    logic [24:0]       w_mant_rnd;
    logic              w_carry;
    logic [EXP_W-1:0]  w_exp;
    logic [FRAC_W-1:0] w_frac;
    float_t            w_result;

    assign w_guard    = r_s2_norm[7];
    assign w_sticky   = |r_s2_norm[6:0];
    assign w_round_up = w_guard && (w_sticky || r_s2_norm[8]);
    assign w_mant_rnd = {1'b0, r_s2_norm[31:8]} + {24'd0, w_round_up};
    assign w_carry    = w_mant_rnd[24];

    // A rounding carry leaves 1.000..0 one binade up, so the fraction clears.
    assign w_exp  = 8'(EXP_TOP) - {2'b00, r_s2_lz} + {7'd0, w_carry};
    assign w_frac = w_carry ? '0 : 23'(w_mant_rnd);

    always_comb begin
        w_result = '0;
        if (!r_s2_zero) begin
            w_result.sign     = r_s2_sign;
            w_result.exponent = w_exp;
            w_result.fraction = w_frac;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_z     <= '0;
        end else if (w_advance) begin
            r_out_valid <= r_s2_valid;
            r_out_z     <= w_result;
        end
    end

`ifdef INT_TO_FLOAT_INEXACT_EN
    logic r_out_inexact;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_inexact <= 1'b0;
        end else if (w_advance) begin
            r_out_inexact <= w_guard || w_sticky;
        end
    end

    assign out_inexact = r_out_inexact;
`endif

endmodule

// File: tb/tb_int_to_float.sv
// Directed and random stimulus for int_to_float with a scoreboard of expected
// words and a small valid-bit model of the three-stage pipeline.
module tb_int_to_float;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_a;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_z;
    logic        out_valid;
    logic        out_ready;
`ifdef INT_TO_FLOAT_INEXACT_EN
    logic        out_inexact;
`endif

    always #5 clk = ~clk;

    int_to_float dut (
        .clk       (clk),
        .rst       (rst),
        .in_a      (in_a),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_z     (out_z),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef INT_TO_FLOAT_INEXACT_EN
        ,
        .out_inexact (out_inexact)
`endif
    );

    typedef struct packed {
        logic [31:0] z;
        logic        inx;
    } expect_t;

    expect_t     scoreQ[$];
    logic [2:0]  modelValid;
    int          nCompared   = 0;
    int          nMismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Reference conversion: exact shift and remainder compare against one half.
    function automatic void refConv(input logic [31:0] a, output logic [31:0] z,
                                    output logic inx);
        logic        s;
        logic [31:0] m, q, rem, half;
        int          p, sh, e;
        z   = 32'd0;
        inx = 1'b0;
        if (a != 32'd0) begin
            s = a[31];
            m = s ? (32'd0 - a) : a;
            p = 31;
            while (m[p] == 1'b0) p--;
            if (p <= 23) begin
                q = m << (23 - p);
            end else begin
                sh   = p - 23;
                q    = m >> sh;
                rem  = m & ((32'd1 << sh) - 32'd1);
                half = 32'd1 << (sh - 1);
                inx  = (rem != 32'd0);
                if (rem > half || (rem == half && q[0])) q = q + 32'd1;
            end
            e = 127 + p;
            if (q[24]) begin
                e = e + 1;
                q = q >> 1;
            end
            z = {s, 8'(e), q[22:0]};
        end
    endfunction

    task automatic applyStimulus(input logic iv, input logic [31:0] ia,
                                 input logic [31:0] expZ, input logic expInx,
                                 input logic ordy, input logic irst,
                                 output logic accepted);
        logic    adv;
        expect_t head;
        expect_t entry;
        @(posedge clk);
        #1;
        rst       = irst;
        in_valid  = iv;
        in_a      = ia;
        out_ready = ordy;
        @(negedge clk);
        adv = !modelValid[2] || ordy;
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, adv});
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, modelValid[2]});
        if (modelValid[2] && scoreQ.size() > 0) begin
            head = scoreQ[0];
            checkOutput("out_z", out_z, head.z);
`ifdef INT_TO_FLOAT_INEXACT_EN
            checkOutput("out_inexact", {31'd0, out_inexact}, {31'd0, head.inx});
`endif
            if (ordy) void'(scoreQ.pop_front());
        end
        accepted = iv && adv && !irst;
        if (irst) begin
            modelValid = '0;
            scoreQ.delete();
        end else if (adv) begin
            modelValid = {modelValid[1:0], iv};
            if (iv) begin
                entry.z   = expZ;
                entry.inx = expInx;
                scoreQ.push_back(entry);
            end
        end
    endtask

    task automatic drain(input logic randomReady);
        logic acc;
        logic ordy;
        for (int c = 0; c < 64 && modelValid != 3'b000; c++) begin
            ordy = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, ordy, 1'b0, acc);
        end
        checkOutput("drain", {29'd0, modelValid}, 32'd0);
    endtask

    logic [31:0] dirA[12] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000000,
                              32'h7FFFFFFF, 32'h80000000, 32'd16777217,
                              32'd16777219, 32'd16777221, 32'd16777216,
                              32'd3,        32'hFFFFFFFB, 32'd100};
    logic [31:0] dirZ[12] = '{32'h3F800000, 32'hBF800000, 32'h00000000,
                              32'h4F000000, 32'hCF000000, 32'h4B800000,
                              32'h4B800002, 32'h4B800002, 32'h4B800000,
                              32'h40400000, 32'hC0A00000, 32'h42C80000};
    logic        dirI[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                              1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        latExp[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        logic        acc;
        logic        ordy;
        logic        iv;
        logic [31:0] a, z;
        logic        inx;
        int          idx;
        int          sent;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = 32'd0;
        out_ready  = 1'b1;
        modelValid = '0;

        $display("[TB] reset");
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, acc);
        checkOutput("rst_out_z", out_z, 32'd0);
`ifdef INT_TO_FLOAT_INEXACT_EN
        checkOutput("rst_inexact", {31'd0, out_inexact}, 32'd0);
`endif
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, acc);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

        $display("[TB] basic stream and latency");
        for (int i = 0; i < 7; i++) begin
            if (i < 3) applyStimulus(1'b1, dirA[i], dirZ[i], dirI[i], 1'b1, 1'b0, acc);
            else       applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, acc);
            checkOutput("latency", {31'd0, out_valid}, {31'd0, latExp[i]});
        end

        $display("[TB] extremes and ties");
        for (int i = 3; i < 12; i++) begin
            applyStimulus(1'b1, dirA[i], dirZ[i], dirI[i], 1'b1, 1'b0, acc);
        end
        drain(1'b0);

        $display("[TB] back-pressure");
        idx = 0;
        for (int c = 0; c < 200 && idx < 10; c++) begin
            a    = 32'd1000 + 32'(idx);
            refConv(a, z, inx);
            ordy = 1'($urandom_range(0, 1));
            applyStimulus(1'b1, a, z, inx, ordy, 1'b0, acc);
            if (acc) idx++;
        end
        checkOutput("bp_sent", 32'(idx), 32'd10);
        drain(1'b1);

        $display("[TB] random sweep");
        sent = 0;
        for (int c = 0; c < 40000 && sent < 10000; c++) begin
            a    = $urandom;
            refConv(a, z, inx);
            iv   = ($urandom_range(0, 9) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            applyStimulus(iv, a, z, inx, ordy, 1'b0, acc);
            if (acc) sent++;
        end
        checkOutput("sweep_sent", 32'(sent), 32'd10000);
        drain(1'b0);

        $display("[TB] reset mid-flight");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, dirA[9 + i], dirZ[9 + i], dirI[9 + i], 1'b1, 1'b0, acc);
        end
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, acc);
            checkOutput("post_rst_valid", {31'd0, out_valid}, 32'd0);
        end
        checkOutput("post_rst_ready", {31'd0, in_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
